mem_arbiter: RTL and testbench

Two-requester memory-port arbiter for the pipelined MIPS core. It shares one SRAM-like bus between instruction fetch (IF stage) and data access (MEM stage), with a single outstanding transaction at a time and round-robin on ties. It returns read data with a one-cycle `ok` pulse to the winning requester and drives a combinational `stall` to the hazard logic while any request is unserved.

---
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory-port arbiter: instruction fetch and data access share one
// SRAM-like bus, one outstanding transaction, round-robin on simultaneous requests.
//
// state | meaning
// IDLE  | no transaction; pick a winner from the pending requests
// ADDR  | bus_req asserted with latched payload, waiting for bus_addr_ok
// DATA  | address accepted, waiting for bus_data_ok
// RESP  | ok pulse to the owner, remember it as last served
module mem_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_rdata,
   output logic        inst_ok,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_ok,
   output logic        bus_req,
   output logic        bus_wr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_addr_ok,
   input  logic        bus_data_ok,
   input  logic [31:0] bus_rdata,
   output logic        stall
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADDR = 2'd1;
   localparam logic [1:0] DATA = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   logic [1:0] state;
   logic       owner;
   logic       last;
   logic       grantData;
   logic       grantAny;

   // On a tie the data side wins unless it was the one served last.
   always_comb begin
      grantData = data_req & (~inst_req | ~last);
      grantAny  = inst_req | data_req;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last       <= 1'b0;
         bus_req    <= 1'b0;
         bus_wr     <= 1'b0;
         bus_wstrb  <= 4'h0;
         bus_addr   <= 32'h0;
         bus_wdata  <= 32'h0;
         inst_ok    <= 1'b0;
         data_ok    <= 1'b0;
         inst_rdata <= 32'h0;
         data_rdata <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (grantAny) begin
                  owner   <= grantData;
                  bus_req <= 1'b1;
                  state   <= ADDR;
                  if (grantData) begin
                     bus_wr    <= data_wr;
                     bus_wstrb <= data_wr ? data_wstrb : 4'h0;
                     bus_addr  <= data_addr;
                     bus_wdata <= data_wdata;
                  end else begin
                     bus_wr    <= 1'b0;
                     bus_wstrb <= 4'h0;
                     bus_addr  <= inst_addr;
                     bus_wdata <= 32'h0;
                  end
               end
            end
            ADDR: begin
               if (bus_addr_ok) begin
                  bus_req <= 1'b0;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (bus_data_ok) begin
                  if (owner) begin
                     data_rdata <= bus_rdata;
                     data_ok    <= 1'b1;
                  end else begin
                     inst_rdata <= bus_rdata;
                     inst_ok    <= 1'b1;
                  end
                  state <= RESP;
               end
            end
            default: begin
               inst_ok <= 1'b0;
               data_ok <= 1'b0;
               last    <= owner;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign stall = (inst_req & ~inst_ok) | (data_req & ~data_ok);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: the bench plays both requesters and the bus slave and
// predicts each transaction's winner, payload, response and stall from the arbitration rules.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        inst_req = 1'b0;
   logic [31:0] inst_addr = 32'h0;
   logic [31:0] inst_rdata;
   logic        inst_ok;
   logic        data_req = 1'b0;
   logic        data_wr = 1'b0;
   logic [3:0]  data_wstrb = 4'h0;
   logic [31:0] data_addr = 32'h0;
   logic [31:0] data_wdata = 32'h0;
   logic [31:0] data_rdata;
   logic        data_ok;
   logic        bus_req;
   logic        bus_wr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_addr_ok = 1'b0;
   logic        bus_data_ok = 1'b0;
   logic [31:0] bus_rdata = 32'h0;
   logic        stall;

   int checks = 0;
   int errors = 0;

   // reference state: who was served last, and what each rdata register should hold
   bit          lastData = 1'b0;
   logic [31:0] expInstRd = 32'h0;
   logic [31:0] expDataRd = 32'h0;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ok(inst_ok),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ok(data_ok),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
      .bus_rdata(bus_rdata), .stall(stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chkAllZero(input string tag);
      chk({tag, "_bus_req"}, bus_req, 0);
      chk({tag, "_bus_wr"}, bus_wr, 0);
      chk({tag, "_bus_wstrb"}, bus_wstrb, 0);
      chk({tag, "_bus_addr"}, bus_addr, 0);
      chk({tag, "_bus_wdata"}, bus_wdata, 0);
      chk({tag, "_inst_ok"}, inst_ok, 0);
      chk({tag, "_data_ok"}, data_ok, 0);
      chk({tag, "_inst_rdata"}, inst_rdata, 0);
      chk({tag, "_data_rdata"}, data_rdata, 0);
   endtask

   // Runs one whole transaction starting in an IDLE cycle with at least one request
   // pending; returns at #1 after the edge that ends the ok cycle.
   task automatic doTxn(input int addrDly, input int dataDly, input bit spurious,
                        input logic [31:0] rd, output bit winData);
      logic [31:0] eAddr, eWdata;
      logic        eWr;
      logic [3:0]  eStrb;
      bit          otherPend;
      winData = data_req && (!inst_req || !lastData);
      if (winData) begin
         eAddr = data_addr; eWr = data_wr; eStrb = data_wr ? data_wstrb : 4'h0;
         eWdata = data_wdata; otherPend = inst_req;
      end else begin
         eAddr = inst_addr; eWr = 1'b0; eStrb = 4'h0; eWdata = 32'h0; otherPend = data_req;
      end

      @(negedge clk);
      chk("idle_bus_req", bus_req, 0);
      chk("idle_stall", stall, 1);
      chk("idle_inst_ok", inst_ok, 0);
      chk("idle_data_ok", data_ok, 0);
      nextCycle();

      for (int i = 0; i <= addrDly; i++) begin
         bus_addr_ok = (i == addrDly);
         bus_data_ok = spurious && (i == 0);
         bus_rdata   = $urandom;
         @(negedge clk);
         chk("addr_bus_req", bus_req, 1);
         chk("addr_bus_addr", bus_addr, eAddr);
         chk("addr_bus_wr", bus_wr, eWr);
         chk("addr_bus_wstrb", bus_wstrb, eStrb);
         if (winData) chk("addr_bus_wdata", bus_wdata, eWdata);
         chk("addr_ok_quiet", inst_ok | data_ok, 0);
         chk("addr_stall", stall, 1);
         nextCycle();
      end
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;

      for (int i = 0; i <= dataDly; i++) begin
         bus_data_ok = (i == dataDly);
         bus_addr_ok = spurious && (i == 0);
         bus_rdata   = (i == dataDly) ? rd : 32'($urandom);
         @(negedge clk);
         chk("data_bus_req", bus_req, 0);
         chk("data_ok_quiet", inst_ok | data_ok, 0);
         chk("data_stall", stall, 1);
         nextCycle();
      end
      bus_data_ok = 1'b0;
      bus_addr_ok = 1'b0;
      bus_rdata   = $urandom;

      if (winData) expDataRd = rd; else expInstRd = rd;
      lastData = winData;
      @(negedge clk);
      chk("resp_inst_ok", inst_ok, !winData);
      chk("resp_data_ok", data_ok, winData);
      chk("resp_inst_rdata", inst_rdata, expInstRd);
      chk("resp_data_rdata", data_rdata, expDataRd);
      chk("resp_stall", stall, otherPend);
      chk("resp_bus_req", bus_req, 0);
      nextCycle();
   endtask

   task automatic newReqs();
      if (!inst_req && $urandom_range(0, 2) != 0) begin
         inst_req  = 1'b1;
         inst_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_req && $urandom_range(0, 2) != 0) begin
         data_req   = 1'b1;
         data_wr    = $urandom_range(0, 1);
         data_wstrb = $urandom_range(0, 15);
         data_addr  = $urandom & 32'hFFFF_FFFC;
         data_wdata = $urandom;
      end
   endtask

   task automatic dropWinner(input bit winData);
      if (winData) data_req = 1'b0; else inst_req = 1'b0;
   endtask

   bit w;

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chkAllZero("reset");
      chk("reset_stall", stall, 0);
      nextCycle();
      rst = 1'b1;
      nextCycle();

      // tie right after reset: data first, then inst
      inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
      data_req = 1'b1; data_addr = 32'h8000_1000; data_wr = 1'b0; data_wstrb = 4'h0;
      data_wdata = 32'h1111_2222;
      doTxn(0, 0, 0, 32'hA5A5_0001, w); dropWinner(w);
      doTxn(0, 0, 0, 32'hA5A5_0002, w); dropWinner(w);

      // single fetch at minimum latency
      inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
      doTxn(0, 0, 0, 32'h2408_0001, w); dropWinner(w);
      @(negedge clk);
      chk("fetch_ok_one_cycle", inst_ok, 0);
      chk("fetch_idle_stall", stall, 0);
      nextCycle();

      // store on a slow bus
      data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'h3; data_addr = 32'h8000_2000;
      data_wdata = 32'hDEAD_BEEF;
      doTxn(3, 2, 0, 32'h0BAD_F00D, w); dropWinner(w);

      // load with byte enables that must be forced off, and a spurious handshake
      data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'hF; data_addr = 32'h8000_3000;
      data_wdata = 32'h5555_AAAA;
      doTxn(2, 1, 1, 32'h1357_9BDF, w); dropWinner(w);

      // round-robin with both requests held over four transactions
      inst_req = 1'b1; inst_addr = 32'h0040_0000;
      data_req = 1'b1; data_addr = 32'h1000_0000; data_wr = 1'b0;
      for (int t = 0; t < 4; t++) begin
         doTxn(t % 2, (t + 1) % 2, 0, 32'($urandom), w);
         if (w) data_addr = data_addr + 32'h4; else inst_addr = inst_addr + 32'h4;
      end
      inst_req = 1'b0; data_req = 1'b0;
      nextCycle();

      // randomized traffic
      for (int t = 0; t < 60; t++) begin
         newReqs();
         if (!inst_req && !data_req) begin
            @(negedge clk);
            chk("rand_idle_bus_req", bus_req, 0);
            chk("rand_idle_stall", stall, 0);
            nextCycle();
         end else begin
            doTxn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2) == 0,
                  32'($urandom), w);
            dropWinner(w);
         end
      end
      inst_req = 1'b0; data_req = 1'b0;
      nextCycle();

      // reset during DATA of a store
      data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF; data_addr = 32'h8000_4000;
      data_wdata = 32'hCAFE_F00D;
      nextCycle();
      bus_addr_ok = 1'b1;
      nextCycle();
      bus_addr_ok = 1'b0;
      #2 rst = 1'b0;
      #1 chkAllZero("midrst");
      data_req = 1'b0;
      inst_req = 1'b1; inst_addr = 32'h0040_0100;
      nextCycle();
      rst = 1'b1;
      lastData = 1'b0; expInstRd = 32'h0; expDataRd = 32'h0;
      doTxn(0, 0, 0, 32'h7777_0001, w); dropWinner(w);

      // tie after mid-transaction reset and one inst service: data wins
      inst_req = 1'b1; inst_addr = 32'h0040_0200;
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_5000;
      doTxn(1, 0, 0, 32'h7777_0002, w); dropWinner(w);
      doTxn(0, 1, 0, 32'h7777_0003, w); dropWinner(w);
      nextCycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
